lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 34 +++
 rtl/lsu_ctrl.sv | 145 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// LSU shared types: access-size encoding, FSM states and lane helpers.
// Imported by lsu_align and lsu_ctrl.
package lsu_pkg;

  typedef enum logic [1:0] {
    MT_BYTE  = 2'b00,
    MT_HALF  = 2'b01,
    MT_WORD  = 2'b10,
    MT_WORDX = 2'b11
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC0 = 2'b01,
    S_ACC1 = 2'b10,
    S_RESP = 2'b11
  } lsu_state_e;

  // Upper nibble holds the lanes that spill into the next word.
  function automatic logic [7:0] lsu_be(
    input mem_type_e  t,
    input logic [1:0] off
  );
    logic [7:0] base;
    unique case (t)
      MT_BYTE: base = 8'b0000_0001;
      MT_HALF: base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  function automatic logic lsu_misaligned(
    input mem_type_e  t,
    input logic [1:0] off
  );
    logic m;
    unique case (t)
      MT_BYTE: m = 1'b0;
      MT_HALF: m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// LSU lane alignment: store-data lane shifting and load
// extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_type_e   type_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic        hi_sel_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [63:0] wsh;
  logic [31:0] raw;

  assign sh      = {off_i, 3'b000};
  assign wsh     = {32'b0, wdata_i} << sh;
  assign wdata_o = hi_sel_i ? wsh[63:32] : wsh[31:0];
  assign raw     = 32'({hi_i, lo_i} >> sh);

  always_comb begin
    unique case (type_i)
      MT_BYTE: rdata_o = {{24{sign_i & raw[7]}}, raw[7:0]};
      MT_HALF: rdata_o = {{16{sign_i & raw[15]}}, raw[15:0]};
      default: rdata_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// LSU control: request capture, access FSM and word-memory sequencing.
// Define MISALIGN_SPLIT_EN to split misaligned accesses instead of faulting.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            mem_type_i,
  input  logic                  mem_sign_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i
);

  lsu_state_e            state_q, state_d;
  lsu_state_e            idle_nxt, acc0_nxt;
  mem_type_e             type_q;
  logic                  we_q, sign_q;
  logic [ADDR_WIDTH-1:0] addr_q, word_addr;
  logic [DATA_WIDTH-1:0] wdata_q, lo_q, hi;
  logic [DATA_WIDTH-1:0] wd_lane, ld_data;
  logic [7:0]            be8;
  logic                  accept, acc, acc1, fault;

  assign accept = req_valid_i & req_ready_o;
  assign be8    = lsu_be(type_q, addr_q[1:0]);
  assign acc    = (state_q == S_ACC0) | (state_q == S_ACC1);

`ifdef MISALIGN_SPLIT_EN
  logic [DATA_WIDTH-1:0] hi_q;
  logic                  split;

  assign split    = |be8[7:4];
  assign acc1     = (state_q == S_ACC1);
  assign hi       = hi_q;
  assign fault    = 1'b0;
  assign idle_nxt = S_ACC0;
  assign acc0_nxt = split ? S_ACC1 : S_RESP;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
    end else if (acc1 && mem_ready_i) begin
      hi_q <= mem_rdata_i;
    end
  end
`else
  logic err_q;
  logic mis_in;

  assign mis_in   = lsu_misaligned(mem_type_e'(mem_type_i), addr_i[1:0]);
  assign acc1     = 1'b0;
  assign hi       = '0;
  assign fault    = err_q;
  assign idle_nxt = mis_in ? S_RESP : S_ACC0;
  assign acc0_nxt = S_RESP;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= mis_in;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = idle_nxt;
      S_ACC0: if (mem_ready_i) state_d = acc0_nxt;
`ifdef MISALIGN_SPLIT_EN
      S_ACC1: if (mem_ready_i) state_d = S_RESP;
`endif
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      type_q  <= MT_BYTE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q  <= mem_type_e'(mem_type_i);
        we_q    <= req_we_i;
        sign_q  <= mem_sign_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state_q == S_ACC0 && mem_ready_i) begin
        lo_q <= mem_rdata_i;
      end
    end
  end

  lsu_align u_align (
    .type_i   (type_q),
    .sign_i   (sign_q),
    .off_i    (addr_q[1:0]),
    .hi_sel_i (acc1),
    .wdata_i  (wdata_q),
    .lo_i     (lo_q),
    .hi_i     (hi),
    .wdata_o  (wd_lane),
    .rdata_o  (ld_data)
  );

  // Memory outputs are forced to zero outside an access.
  assign word_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign req_ready_o = (state_q == S_IDLE);
  assign mem_req_o   = acc;
  assign mem_we_o    = acc & we_q;
  assign mem_be_o    = acc ? (acc1 ? be8[7:4] : be8[3:0]) : 4'b0;
  assign mem_addr_o  = acc ? word_addr + {{(ADDR_WIDTH-3){1'b0}}, acc1, 2'b00}
                           : '0;
  assign mem_wdata_o = acc ? wd_lane : '0;

  assign resp_valid_o   = (state_q == S_RESP);
  assign misalign_err_o = resp_valid_o & fault;
  assign rdata_o        = (resp_valid_o & ~we_q & ~fault) ? ld_data : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, reset
// corner case and randomized traffic against a byte-level memory model.
module tb_lsu_ctrl;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, mem_sign_i;
  logic [1:0]  mem_type_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        resp_valid_o, misalign_err_o;
  logic        mem_req_o, mem_we_o, mem_ready_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .mem_type_i     (mem_type_i),
    .mem_sign_i     (mem_sign_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .resp_valid_o   (resp_valid_o),
    .rdata_o        (rdata_o),
    .misalign_err_o (misalign_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ready_i    (mem_ready_i)
  );

  always #5 clk = ~clk;

  logic [7:0] mem  [0:1023];
  logic [7:0] rmem [0:1023];
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    logic [1:0]  mt;
    bit          sg;
    logic [31:0] a;
    logic [31:0] wd;
    int          stall;
    logic [31:0] rd;
    bit          er;
    int          lat;
    int          n;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit we, logic [1:0] mt, bit sg,
                              logic [31:0] a, logic [31:0] wd, int stall,
                              logic [31:0] rd, bit er, int lat, int n,
                              logic [31:0] a0, logic [3:0] be0,
                              logic [31:0] wd0);
    vec_t v;
    v.we = we; v.mt = mt; v.sg = sg; v.a = a; v.wd = wd;
    v.stall = stall; v.rd = rd; v.er = er; v.lat = lat; v.n = n;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
    return v;
  endfunction

  function automatic int size_of(input logic [1:0] mt);
    return (mt == 2'd0) ? 1 : (mt == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [1:0] mt, input logic [31:0] a);
    int sz = size_of(mt);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    logic [9:0] ix;
    for (int b = 0; b < 4; b++) begin
      ix = 10'(a + 32'(b));
      mem[ix]  = w[8*b +: 8];
      rmem[ix] = w[8*b +: 8];
    end
  endtask

  // Little-endian byte gather from the reference memory.
  function automatic logic [31:0] model_load(input logic [1:0] mt,
                                             input bit sg,
                                             input logic [31:0] a);
    int sz = size_of(mt);
    logic [31:0] v = '0;
    logic [9:0]  ix;
    for (int i = 0; i < sz; i++) begin
      ix = 10'(a + 32'(i));
      v  = v | (32'(rmem[ix]) << (8 * i));
    end
    if (sg && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input bit we, input logic [1:0] mt,
                             input logic [31:0] a, input logic [31:0] wd);
    logic [9:0] ix;
    if (we && !(!SPLIT && is_mis(mt, a))) begin
      for (int i = 0; i < size_of(mt); i++) begin
        ix = 10'(a + 32'(i));
        rmem[ix] = wd[8*i +: 8];
      end
    end
  endtask

  // Issues one request and plays the memory side until the response.
  task automatic run_txn(input bit we, input logic [1:0] mt, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int stall,
                         output logic [31:0] rd, output bit er,
                         output int lat, output int n,
                         output logic [31:0] a0, output logic [3:0] be0,
                         output logic [31:0] wd0);
    int          left;
    bit          got, hold;
    logic [31:0] pa, pw;
    logic [3:0]  pb;
    logic        pwe;
    logic [9:0]  ix;
    req_valid_i = 1'b1; req_we_i = we; mem_type_i = mt;
    mem_sign_i = sg; addr_i = a; wdata_i = wd;
    chk("req_ready_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_we_i = 1'($urandom); mem_type_i = 2'($urandom);
    mem_sign_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
    rd = '0; er = 1'b0; lat = 0; n = 0; a0 = '0; be0 = '0; wd0 = '0;
    got = 1'b0; hold = 1'b0; left = stall;
    pa = '0; pw = '0; pb = '0; pwe = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      lat++;
      mem_ready_i = 1'b0;
      if (mem_req_o) begin
        if (hold) begin
          chk("hold_addr", mem_addr_o, pa);
          chk("hold_be", 32'(mem_be_o), 32'(pb));
          chk("hold_wdata", mem_wdata_o, pw);
          chk("hold_we", 32'(mem_we_o), 32'(pwe));
        end
        pa = mem_addr_o; pb = mem_be_o; pw = mem_wdata_o; pwe = mem_we_o;
        if (left > 0) begin
          left--;
          hold = 1'b1;
        end else begin
          hold = 1'b0;
          mem_ready_i = 1'b1;
          mem_rdata_i = rd_word(mem_addr_o);
          if (n == 0) begin
            a0 = mem_addr_o; be0 = mem_be_o; wd0 = mem_wdata_o;
          end
          n++;
          if (mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
              ix = 10'(mem_addr_o + 32'(b));
              if (mem_be_o[b]) mem[ix] = mem_wdata_o[8*b +: 8];
            end
          end
        end
      end else begin
        hold = 1'b0;
        mem_ready_i = 1'($urandom);
        mem_rdata_i = $urandom;
      end
      if (resp_valid_o) begin
        got = 1'b1;
        rd = rdata_o;
        er = misalign_err_o;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got none expected resp_valid_o");
    end
    chk("resp_one_cycle", 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] rd, a0, wd0, erd, a, wd, base;
    logic [3:0]  be0;
    logic [1:0]  mt;
    logic [9:0]  ix;
    bit          er, eer, we, sg, mis, crs, ok;
    int          lat, n, elat, en, stall, sz;

    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    mem_type_i = 2'b0; mem_sign_i = 1'b0; addr_i = '0; wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 8'($urandom);
      rmem[i] = mem[i];
    end
    set_word(32'h100, 32'h4433_2211);
    set_word(32'h104, 32'h8877_6655);
    set_word(32'h200, 32'h80FF_0000);

    #12;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_misalign", 32'(misalign_err_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_be", 32'(mem_be_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    tbl[0]  = mk(0, 2'd0, 1, 32'h203, 0, 0, 32'hFFFF_FF80, 0, 2, 1,
                 32'h200, 4'b1000, 0);
    tbl[1]  = mk(0, 2'd0, 0, 32'h203, 0, 0, 32'h0000_0080, 0, 2, 1,
                 32'h200, 4'b1000, 0);
    tbl[2]  = mk(0, 2'd2, 0, 32'h102, 0, 0,
                 SPLIT ? 32'h6655_4433 : 32'h0, !SPLIT,
                 SPLIT ? 3 : 1, SPLIT ? 2 : 0, 32'h100, 4'b1100, 0);
    tbl[3]  = mk(0, 2'd1, 1, 32'h106, 0, 0, 32'hFFFF_8877, 0, 2, 1,
                 32'h104, 4'b1100, 0);
    tbl[4]  = mk(0, 2'd1, 0, 32'h103, 0, 0,
                 SPLIT ? 32'h0000_5544 : 32'h0, !SPLIT,
                 SPLIT ? 3 : 1, SPLIT ? 2 : 0, 32'h100, 4'b1000, 0);
    tbl[5]  = mk(0, 2'd2, 0, 32'h104, 0, 3, 32'h8877_6655, 0, 5, 1,
                 32'h104, 4'b1111, 0);
    tbl[6]  = mk(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 2, 1,
                 32'h100, 4'b1111, 32'hDEAD_BEEF);
    tbl[7]  = mk(1, 2'd1, 0, 32'h102, 32'h0000_ABCD, 0, 0, 0, 2, 1,
                 32'h100, 4'b1100, 32'hABCD_0000);
    tbl[8]  = mk(1, 2'd0, 0, 32'h101, 32'h0000_005A, 0, 0, 0, 2, 1,
                 32'h100, 4'b0010, 32'h0000_5A00);
    tbl[9]  = mk(0, 2'd1, 1, 32'h101, 0, 0,
                 SPLIT ? 32'hFFFF_CD5A : 32'h0, !SPLIT,
                 SPLIT ? 2 : 1, SPLIT ? 1 : 0, 32'h100, 4'b0110, 0);
    tbl[10] = mk(1, 2'd2, 0, 32'h105, 32'h1234_5678, 0, 0, !SPLIT,
                 SPLIT ? 3 : 1, SPLIT ? 2 : 0, 32'h104, 4'b1110,
                 32'h3456_7800);
    tbl[11] = mk(0, 2'd2, 0, 32'h104, 0, 0,
                 SPLIT ? 32'h3456_7855 : 32'h8877_6655, 0, 2, 1,
                 32'h104, 4'b1111, 0);

    foreach (tbl[i]) begin
      run_txn(tbl[i].we, tbl[i].mt, tbl[i].sg, tbl[i].a, tbl[i].wd,
              tbl[i].stall, rd, er, lat, n, a0, be0, wd0);
      model_store(tbl[i].we, tbl[i].mt, tbl[i].a, tbl[i].wd);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_accesses", i), 32'(n), 32'(tbl[i].n));
      if (tbl[i].n > 0) begin
        chk($sformatf("v%0d_addr0", i), a0, tbl[i].a0);
        chk($sformatf("v%0d_be0", i), 32'(be0), 32'(tbl[i].be0));
        chk($sformatf("v%0d_wdata0", i), wd0, tbl[i].wd0);
      end
    end

    for (int t = 0; t < 150; t++) begin
      we    = 1'($urandom);
      mt    = 2'($urandom_range(0, 3));
      sg    = 1'($urandom);
      a     = 32'h100 + 32'($urandom_range(0, 247));
      wd    = $urandom;
      stall = $urandom_range(0, 2);
      sz    = size_of(mt);
      mis   = is_mis(mt, a);
      crs   = (int'(a[1:0]) + sz) > 4;
      if (!SPLIT && mis) begin
        erd = '0; eer = 1'b1; elat = 1; en = 0;
      end else begin
        erd  = we ? 32'h0 : model_load(mt, sg, a);
        eer  = 1'b0;
        elat = (crs ? 3 : 2) + stall;
        en   = crs ? 2 : 1;
      end
      run_txn(we, mt, sg, a, wd, stall, rd, er, lat, n, a0, be0, wd0);
      model_store(we, mt, a, wd);
      chk("rnd_rdata", rd, erd);
      chk("rnd_err", 32'(er), 32'(eer));
      chk("rnd_latency", 32'(lat), 32'(elat));
      chk("rnd_accesses", 32'(n), 32'(en));
      base = a & 32'hFFFF_FFFC;
      ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
        ix = 10'(base + 32'(k));
        if (mem[ix] !== rmem[ix]) ok = 1'b0;
      end
      chk("rnd_mem_bytes", 32'(ok), 32'd1);
    end

    // Reset while the second half of a split access (or a stalled
    // single access) is outstanding.
    req_valid_i = 1'b1; req_we_i = 1'b0; mem_type_i = 2'd2;
    mem_sign_i = 1'b0; addr_i = SPLIT ? 32'h102 : 32'h104;
    mem_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("rst_seq_acc0_req", 32'(mem_req_o), 32'd1);
    mem_ready_i = SPLIT;
    mem_rdata_i = 32'h0;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    chk("rst_seq_acc_req", 32'(mem_req_o), 32'd1);
    chk("rst_seq_acc_addr", mem_addr_o, 32'h104);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_async_ready", 32'(req_ready_o), 32'd1);
    chk("rst_async_be", 32'(mem_be_o), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_resp", 32'(resp_valid_o), 32'd0);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("post_rst_resp", 32'(resp_valid_o), 32'd0);
      chk("post_rst_ready", 32'(req_ready_o), 32'd1);
      chk("post_rst_mem_req", 32'(mem_req_o), 32'd0);
      @(posedge clk); #1;
    end
    run_txn(0, 2'd2, 0, 32'h100, 0, 1, rd, er, lat, n, a0, be0, wd0);
    chk("post_rst_load", rd, model_load(2'd2, 1'b0, 32'h100));
    chk("post_rst_latency", 32'(lat), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
